conv_seq_ctrl: RTL and testbench
================================

// Module: conv_seq_ctrl
// PURPOSE
//  Sequencer for the 5x5 binary-weight conv datapath (conv engine).
//  Per job: loads 25 1-bit weights into the engine, streams the fmap column by column as 5-row taps,
//  and flags which engine outputs are valid window results. Emits done when the pipeline has drained.
//  Sits between the top-level layer FSM, the weight/fmap memories and the conv engine.
// PARAMETERS
//  K         5   kernel size (weights = K*K)
//  PIPE_LAT  6   engine latency, taps-in cycle -> dout cycle
//  DIM_W     5   width of row/col counters
// PORTS
//  clk            in   1      clock, rising edge
//  rstn           in   1      asynchronous reset, active low
//  start          in   1      job request; accepted only in IDLE
//  state          in   1      layer select, sampled on accepted start: 0 -> Ni=28, 1 -> Ni=12
//  busy           out  1      high from accepted start until the done cycle (inclusive)
//  done           out  1      1-cycle pulse, job complete
//  wt_rd_en       out  1      weight memory read strobe
//  wt_rd_addr     out  8      weight address 0..24, row-major k00..k44
//  conv_start     out  1      engine weight-counter enable; high in LOAD/STREAM/DRAIN
//  conv_weight_en out  1      engine weight capture; wt_rd_en delayed 1 cycle
//  fmap_rd_en     out  1      fmap read strobe; memory returns taps (rows r..r+4 of col c) next cycle
//  fmap_row       out  DIM_W  top row r of the 5-row strip
//  fmap_col       out  DIM_W  column c
//  out_valid      out  1      aligned with engine dout; dout is a complete window result
//  out_row        out  DIM_W  output row of current out_valid
//  out_col        out  DIM_W  output col of current out_valid
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, delay line cleared. Async reset mid-job aborts immediately; no done pulse.
//  FSM: IDLE -> LOAD on start. LOAD -> STREAM after 25 reads. STREAM -> DRAIN after last column of row Ni-K.
//       DRAIN -> IDLE when delay line empty; done=1 in that cycle.
//  start at cycle 0 -> LOAD cycles 1..25: wt_rd_en=1, wt_rd_addr=0..24. conv_weight_en in cycles 2..26.
//  STREAM starts cycle 26: fmap_rd_en=1 every cycle. col 0..Ni-1 inner, row 0..Ni-K outer, no gaps.
//    Read cycles: 24*28=672 (Ni=28), 8*12=96 (Ni=12).
//  Window tag: read with col>=K-1 is tagged; tag + (row,col-K+1) go through a 1+PIPE_LAT stage delay line.
//    Delay line output drives out_valid/out_row/out_col. Tags never cross row boundaries.
//    Cols 0..K-2 of each row are fill cycles (out_valid=0).
//  Outputs/job: (Ni-K+1)^2 = 576 or 64. Rows/cols in raster order; each out_row,out_col pair occurs exactly once.
//  DRAIN: fmap_rd_en=0; done asserted the cycle after the last out_valid.
//  start while busy, including the done cycle: ignored. state is ignored except on accepted start.
//  conv_start=0 in IDLE: engine weight counter rearms to 0 before each job.
//  Counters wrap only via explicit clear at row/col end; no modular overflow.
// CONFIGURATION
//  CONV_SEQ_PERF_EN defined: adds output cycle_cnt [15:0].
//    Cleared on accepted start; increments each busy cycle; holds value after done until next start.
//    Reset value 0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  Reset, then idle 10 cycles -> all outputs 0, busy=0.
//  start, state=0 at cycle 0 -> wt_rd_addr 0..24 in cycles 1..25.
//    First out_valid at cycle 37 with (0,0). 576 out_valid pulses; last (23,23) at cycle 704; done at cycle 705.
//  start, state=1 -> 96 read cycles; 64 out_valid pulses; last (7,7) at cycle 128; done at 129.
//  start re-pulsed at cycles 50 and 705 of a state=0 job -> ignored; no second job.
//    A start at cycle 706 is accepted.
//  rstn low at cycle 300 mid-STREAM -> outputs 0 immediately; no done.
//    A new job after release completes normally.
//  CONV_SEQ_PERF_EN: state=0 job -> cycle_cnt=705 after done, held.
//    A state=1 job then reads 129.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: job sequencer for the 5x5 binary-weight conv engine.
// Loads K*K weights, streams fmap columns as K-row taps, tags complete
// windows through a delay line matched to the engine latency, pulses done
// once the last tagged result has left the engine.
// Optional feature macro: CONV_SEQ_PERF_EN adds a 16-bit busy-cycle counter.
module conv_seq_ctrl #(
  parameter int unsigned K        = 5,
  parameter int unsigned PIPE_LAT = 6,
  parameter int unsigned DIM_W    = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             state,
  output logic             busy,
  output logic             done,
  output logic             wt_rd_en,
  output logic [7:0]       wt_rd_addr,
  output logic             conv_start,
  output logic             conv_weight_en,
  output logic             fmap_rd_en,
  output logic [DIM_W-1:0] fmap_row,
  output logic [DIM_W-1:0] fmap_col,
  output logic             out_valid,
  output logic [DIM_W-1:0] out_row,
`ifdef CONV_SEQ_PERF_EN
  output logic [15:0]      cycle_cnt,
`endif
  output logic [DIM_W-1:0] out_col
);

  localparam int unsigned NW  = K * K;
  localparam int unsigned DL  = 1 + PIPE_LAT;
  localparam int unsigned NI0 = 28;
  localparam int unsigned NI1 = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN
  } st_t;

  st_t              st_q, st_d;
  logic [DIM_W-1:0] ni_q, ni_d;

  logic             busy_d, done_d, wt_rd_en_d, conv_start_d, fmap_rd_en_d;
  logic [7:0]       wt_rd_addr_d;
  logic [DIM_W-1:0] fmap_row_d, fmap_col_d;
  logic             accept_c;
  logic             tag_c;

  logic [DL-1:0]    dl_v;
  logic [DIM_W-1:0] dl_row [DL];
  logic [DIM_W-1:0] dl_col [DL];

  // A start is taken only when idle and not in the done cycle
  assign accept_c = (st_q == S_IDLE) && start && !busy;

  // A read is a complete window once K columns of the row have been seen
  assign tag_c = fmap_rd_en && (fmap_col >= DIM_W'(K - 1));

  // Next-state and next-output logic
  always_comb begin
    st_d         = st_q;
    ni_d         = ni_q;
    done_d       = 1'b0;
    wt_rd_en_d   = 1'b0;
    wt_rd_addr_d = 8'd0;
    fmap_rd_en_d = 1'b0;
    fmap_row_d   = '0;
    fmap_col_d   = '0;
    case (st_q)
      S_IDLE: begin
        if (accept_c) begin
          st_d       = S_LOAD;
          ni_d       = state ? DIM_W'(NI1) : DIM_W'(NI0);
          wt_rd_en_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (wt_rd_addr == 8'(NW - 1)) begin
          st_d         = S_STREAM;
          fmap_rd_en_d = 1'b1;
        end else begin
          wt_rd_en_d   = 1'b1;
          wt_rd_addr_d = wt_rd_addr + 8'd1;
        end
      end
      S_STREAM: begin
        if (fmap_col == ni_q - DIM_W'(1)) begin
          if (fmap_row == ni_q - DIM_W'(K)) begin
            st_d = S_DRAIN;
          end else begin
            fmap_rd_en_d = 1'b1;
            fmap_row_d   = fmap_row + DIM_W'(1);
          end
        end else begin
          fmap_rd_en_d = 1'b1;
          fmap_row_d   = fmap_row;
          fmap_col_d   = fmap_col + DIM_W'(1);
        end
      end
      S_DRAIN: begin
        // Only the final stage may still be occupied: it is out_valid this cycle
        if (dl_v[DL-2:0] == '0) begin
          st_d   = S_IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
    conv_start_d = (st_d != S_IDLE);
    busy_d       = (st_d != S_IDLE) || done_d;
  end

  // State and layer-size registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q <= S_IDLE;
      ni_q <= '0;
    end else begin
      st_q <= st_d;
      ni_q <= ni_d;
    end
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      wt_rd_en       <= 1'b0;
      wt_rd_addr     <= 8'd0;
      conv_start     <= 1'b0;
      conv_weight_en <= 1'b0;
      fmap_rd_en     <= 1'b0;
      fmap_row       <= '0;
      fmap_col       <= '0;
    end else begin
      busy           <= busy_d;
      done           <= done_d;
      wt_rd_en       <= wt_rd_en_d;
      wt_rd_addr     <= wt_rd_addr_d;
      conv_start     <= conv_start_d;
      conv_weight_en <= wt_rd_en;
      fmap_rd_en     <= fmap_rd_en_d;
      fmap_row       <= fmap_row_d;
      fmap_col       <= fmap_col_d;
    end
  end

  // Window tag delay line: one cycle of memory read plus engine latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dl_v <= '0;
      for (int i = 0; i < int'(DL); i++) begin
        dl_row[i] <= '0;
        dl_col[i] <= '0;
      end
    end else begin
      dl_v      <= {dl_v[DL-2:0], tag_c};
      dl_row[0] <= tag_c ? fmap_row : '0;
      dl_col[0] <= tag_c ? fmap_col - DIM_W'(K - 1) : '0;
      for (int i = 1; i < int'(DL); i++) begin
        dl_row[i] <= dl_row[i-1];
        dl_col[i] <= dl_col[i-1];
      end
    end
  end

  assign out_valid = dl_v[DL-1];
  assign out_row   = dl_row[DL-1];
  assign out_col   = dl_col[DL-1];

`ifdef CONV_SEQ_PERF_EN
  // Busy-cycle counter, cleared on each accepted job and held afterwards
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= 16'd0;
    end else if (accept_c) begin
      cycle_cnt <= 16'd0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: directed/randomized bench with a job-timeline reference model.
module tb_conv_seq_ctrl;
  localparam int unsigned DIM_W = 5;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             state = 1'b0;
  logic             busy, done, wt_rd_en, conv_start, conv_weight_en, fmap_rd_en, out_valid;
  logic [7:0]       wt_rd_addr;
  logic [DIM_W-1:0] fmap_row, fmap_col, out_row, out_col;
`ifdef CONV_SEQ_PERF_EN
  logic [15:0]      cycle_cnt;
`endif

  int checks    = 0;
  int failures  = 0;
  int perf_hold = 0;
  int nvalid;
  int first_k;

  conv_seq_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .state          (state),
    .busy           (busy),
    .done           (done),
    .wt_rd_en       (wt_rd_en),
    .wt_rd_addr     (wt_rd_addr),
    .conv_start     (conv_start),
    .conv_weight_en (conv_weight_en),
    .fmap_rd_en     (fmap_rd_en),
    .fmap_row       (fmap_row),
    .fmap_col       (fmap_col),
    .out_valid      (out_valid),
    .out_row        (out_row),
`ifdef CONV_SEQ_PERF_EN
    .cycle_cnt      (cycle_cnt),
`endif
    .out_col        (out_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int k, input bit b, input bit d, input bit cs, input bit wre,
                         input int addr, input bit wen, input bit fre, input int row,
                         input int col, input bit ov, input int orow, input int ocol,
                         input int cnt);
    string s;
    s = $sformatf("k%0d", k);
    chk({"busy@", s}, 32'(busy), 32'(b));
    chk({"done@", s}, 32'(done), 32'(d));
    chk({"conv_start@", s}, 32'(conv_start), 32'(cs));
    chk({"wt_rd_en@", s}, 32'(wt_rd_en), 32'(wre));
    chk({"wt_rd_addr@", s}, 32'(wt_rd_addr), 32'(addr));
    chk({"conv_weight_en@", s}, 32'(conv_weight_en), 32'(wen));
    chk({"fmap_rd_en@", s}, 32'(fmap_rd_en), 32'(fre));
    chk({"fmap_row@", s}, 32'(fmap_row), 32'(row));
    chk({"fmap_col@", s}, 32'(fmap_col), 32'(col));
    chk({"out_valid@", s}, 32'(out_valid), 32'(ov));
    chk({"out_row@", s}, 32'(out_row), 32'(orow));
    chk({"out_col@", s}, 32'(out_col), 32'(ocol));
`ifdef CONV_SEQ_PERF_EN
    chk({"cycle_cnt@", s}, 32'(cycle_cnt), 32'(cnt));
`else
    if (cnt < 0) $display("unexpected negative count");
`endif
  endtask

  task automatic chk_quiet(input int k);
    chk_all(k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, perf_hold);
  endtask

  // Expected outputs at offset k after the start-accept cycle of a job on an Ni x Ni fmap
  task automatic expect_at(input int k, input int ni);
    int r, kd, j, rd, rr, cc, orow, ocol, cnt;
    bit wre, wen, fre, ov;
    r    = (ni - 4) * ni;
    kd   = 33 + r;
    wre  = (k >= 1) && (k <= 25);
    wen  = (k >= 2) && (k <= 26);
    fre  = (k >= 26) && (k <= 25 + r);
    rd   = k - 26;
    rr   = fre ? rd / ni : 0;
    cc   = fre ? rd % ni : 0;
    j    = k - 33;
    ov   = (j >= 0) && (j < r) && ((j % ni) >= 4);
    orow = ov ? j / ni : 0;
    ocol = ov ? (j % ni) - 4 : 0;
    cnt  = (k == 0) ? perf_hold : k - 1;
    chk_all(k, (k >= 1) && (k <= kd), k == kd, (k >= 1) && (k < kd), wre, wre ? k - 1 : 0,
            wen, fre, rr, cc, ov, orow, ocol, cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      state = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_quiet(-1);
    end
  endtask

  // Run one job; abort_k >= 0 pulls rstn low at that offset instead of finishing
  task automatic job(input bit sel, input int abort_k, input bit pulse_fixed);
    int ni, kd, kend;
    ni      = sel ? 12 : 28;
    kd      = 33 + (ni - 4) * ni;
    kend    = (abort_k >= 0) ? abort_k : kd;
    nvalid  = 0;
    first_k = -1;
    for (int k = 0; k <= kend; k++) begin
      @(posedge clk); #1;
      if (k == abort_k) begin
        rstn  = 1'b0;
        start = 1'b0;
      end else begin
        start = (k == 0) || (pulse_fixed && (k == 50 || k == kd)) ||
                ((k > 0) && ($urandom_range(0, 9) == 0));
        state = (k == 0) ? sel : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (k == abort_k) begin
        perf_hold = 0;
        chk_quiet(k);
      end else begin
        expect_at(k, ni);
        if (out_valid === 1'b1) begin
          if (first_k < 0) first_k = k;
          nvalid++;
        end
      end
    end
    if (abort_k < 0) perf_hold = kd;
  endtask

  initial begin
    // Reset and quiet idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet(-1);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(10);

    // Ni=28 job with starts re-pulsed at 50 and in the done cycle
    job(1'b0, -1, 1'b1);
    chk("n_valid_28", 32'(nvalid), 32'd576);
    chk("first_valid_28", 32'(first_k), 32'd37);

    // Start in the cycle after done is accepted: Ni=12 job
    job(1'b1, -1, 1'b1);
    chk("n_valid_12", 32'(nvalid), 32'd64);
    chk("first_valid_12", 32'(first_k), 32'd37);
    idle(4);
`ifdef CONV_SEQ_PERF_EN
    chk("cycle_cnt_hold_12", 32'(cycle_cnt), 32'd129);
`endif

    // Randomized layer selects and idle gaps
    for (int n = 0; n < 3; n++) begin
      idle(int'($urandom_range(1, 20)));
      job(1'($urandom_range(0, 1)), -1, 1'b0);
    end
    idle(3);

    // Async reset in the middle of streaming aborts without done
    job(1'b0, 300, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_quiet(-2);
    end
    @(posedge clk); #1;
    start = 1'b0;
    rstn  = 1'b1;
    @(negedge clk);
    chk_quiet(-3);
    idle(5);

    // A fresh job after the abort completes normally
    job(1'b0, -1, 1'b0);
    chk("n_valid_after_abort", 32'(nvalid), 32'd576);
    idle(3);
`ifdef CONV_SEQ_PERF_EN
    chk("cycle_cnt_hold_28", 32'(cycle_cnt), 32'd705);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
